// File: rtl/data_memory_be_if.sv
// Request/response bus between the execute stage and the byte-addressed
// data memory.
//   req_valid  : access request this cycle (always accepted)
//   req_we     : 1 = store, 0 = load
//   req_funct3 : RV32I load/store funct3
//   req_addr   : byte address
//   req_wdata  : right-aligned store data
//   rsp_valid  : response for the previous cycle's request
//   rsp_rdata  : extended load data, 0 for stores and faults
//   rsp_fault  : previous request faulted and had no effect
interface data_memory_be_if;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  rsp_valid, rsp_rdata, rsp_fault
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output rsp_valid, rsp_rdata, rsp_fault
   );
endinterface

// File: rtl/data_memory_be.sv
// Byte-addressed data memory with RV32I funct3 decoding.
// Byte/halfword/word stores use byte-lane enables; loads are sign- or
// zero-extended. Misaligned, out-of-range and illegal-width accesses are
// faulted and have no effect. Responses are registered (one-cycle latency).
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears the response register and
//           drops any request presented in the same cycle
//   bus   : request/response bus (slave side)
//   ADDR_WIDTH : word-address bits, depth = 2**ADDR_WIDTH words
module data_memory_be #(
   parameter int unsigned ADDR_WIDTH = 6
) (
   input  logic            clk,
   input  logic            reset,
   data_memory_be_if.slave bus
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_BAD  = 2'b11
   } size_e;

   logic [31:0]           mem [DEPTH];

   size_e                 size;
   logic [ADDR_WIDTH-1:0] widx;
   logic [1:0]            lane;
   logic                  funct_ok;
   logic                  misaligned;
   logic                  out_of_range;
   logic                  fault;
   logic [3:0]            be;
   logic [31:0]           wdata_rep;
   logic                  do_write;
   logic [31:0]           rword;
   logic [15:0]           rlow;
   logic [31:0]           load_data;

   assign size = size_e'(bus.req_funct3[1:0]);
   assign widx = bus.req_addr[ADDR_WIDTH+1:2];
   assign lane = bus.req_addr[1:0];

   // Fault detection
   always_comb begin
      funct_ok = 1'b0;
      if (bus.req_we) begin
         funct_ok = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                    (bus.req_funct3 == 3'b010);
      end else begin
         funct_ok = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                    (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                    (bus.req_funct3 == 3'b101);
      end

      misaligned = 1'b0;
      case (size)
         SZ_HALF: misaligned = lane[0];
         SZ_WORD: misaligned = (lane != 2'b00);
         default: misaligned = 1'b0;
      endcase

      // Any address bit above the word index makes the access out of range
      out_of_range = ((bus.req_addr >> (ADDR_WIDTH + 2)) != 32'd0);

      fault = !funct_ok || misaligned || out_of_range;
   end

   // Byte enables and lane-replicated store data
   always_comb begin
      be        = '0;
      wdata_rep = bus.req_wdata;
      case (size)
         SZ_BYTE: begin
            be[lane]  = 1'b1;
            wdata_rep = {4{bus.req_wdata[7:0]}};
         end
         SZ_HALF: begin
            be        = lane[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{bus.req_wdata[15:0]}};
         end
         SZ_WORD: begin
            be        = 4'b1111;
            wdata_rep = bus.req_wdata;
         end
         default: begin
            be        = '0;
            wdata_rep = bus.req_wdata;
         end
      endcase
   end

   assign do_write = bus.req_valid && bus.req_we && !fault && !reset;

   // Storage: not reset; unenabled bytes keep their value
   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem[widx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
         end
      end
   end

   // Load extraction: shift the addressed lane down to bit 0, then extend
   assign rword = mem[widx];
   assign rlow  = 16'(rword >> {lane, 3'b000});

   always_comb begin
      load_data = '0;
      case (bus.req_funct3)
         3'b000:  load_data = {{24{rlow[7]}}, rlow[7:0]};
         3'b001:  load_data = {{16{rlow[15]}}, rlow[15:0]};
         3'b010:  load_data = rword;
         3'b100:  load_data = {24'd0, rlow[7:0]};
         3'b101:  load_data = {16'd0, rlow[15:0]};
         default: load_data = '0;
      endcase
   end

   // Response register
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_fault <= 1'b0;
         bus.rsp_rdata <= '0;
      end else begin
         bus.rsp_valid <= bus.req_valid;
         bus.rsp_fault <= bus.req_valid && fault;
         if (bus.req_valid && !bus.req_we && !fault) begin
            bus.rsp_rdata <= load_data;
         end else begin
            bus.rsp_rdata <= '0;
         end
      end
   end

endmodule

// File: doc/data_memory_be.md
# data_memory_be

Parametrised, byte-addressed data memory for the RISC-V softcore, the next generation of the single-word, word-indexed data RAM. It decodes RV32I load/store `funct3` directly: byte/halfword/word stores with byte-lane enables, and sign- or zero-extended loads. It reports misaligned, out-of-range and illegal-width accesses as faults. Reads are registered with a fixed one-cycle latency; it sits between the execute stage and writeback.

## Interface
- `ADDR_WIDTH`, default 6: word-address bits; depth is `2**ADDR_WIDTH` words (default 64 words = 256 bytes).
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  access request this cycle; always accepted, no back-pressure.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (bits 7:0 for SB, 15:0 for SH).
- `rsp_valid`  out  1  response for the request of the previous cycle.
- `rsp_rdata`  out  32  extended load data; 0 for stores and faults.
- `rsp_fault`  out  1  request was faulted and had no effect.

## Operation
- Storage: `2**ADDR_WIDTH` x 32-bit words. Word index = `req_addr[ADDR_WIDTH+1:2]`; byte lane = `req_addr[1:0]`, little-endian (lane 0 = bits 7:0).
- Contents are not cleared by `reset` and are undefined until written.
- Fault conditions (evaluated in the request cycle; any one suffices):
  - misaligned: halfword with `addr[0]=1`, or word with `addr[1:0]!=0`;
  - out of range: `req_addr[31:ADDR_WIDTH+2]` nonzero;
  - illegal funct3: loads 011/110/111, stores any value other than 000/001/010.
- A faulted store writes nothing.
- Stores: byte enables are derived from size and lane.
  - SB: lane `a[1:0]`, data `wdata[7:0]` replicated to all lanes.
  - SH: lanes {a1*2, a1*2+1}, data `wdata[15:0]` replicated to both halves.
  - SW: all four lanes.
  - Unenabled bytes are preserved.
- Loads: the addressed word is extracted by lane, then extended: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- Response register, updated every cycle:
  - `rsp_valid <= req_valid`;
  - `rsp_fault <= req_valid & fault`;
  - `rsp_rdata <=` load result if a valid, non-faulted load, else 0.
- Same-address store in cycle N, load in cycle N+1: the load returns the newly written data.
- A store and a load cannot occur in the same cycle (single request port).

## Timing
- Store commits at the rising edge ending the request cycle.
- Load data appears in `rsp_rdata` one cycle after the request and holds for exactly one cycle (it is overwritten by the next cycle's response).
- Throughput: one request per cycle, back-to-back, with no bubbles.
- Reset (synchronous): `rsp_valid=0`, `rsp_fault=0`, `rsp_rdata=0` on the edge where `reset=1`.
  - A request presented during a reset cycle is dropped: no write, no response.
  - Reset asserted in the cycle after a request suppresses that request's response; a store already committed stays committed.
- No combinational path from request inputs to outputs.

## Test plan
- Reset: hold `reset` 2 cycles with `req_valid=1`, SW of 0xDEADBEEF to 0x10 -> outputs all 0 throughout. A subsequent LW from 0x10 must not return 0xDEADBEEF (the write was dropped).
- Word/byte/halfword: SW 0x11223344 @0x20.
  - Then SB 0xAA @0x21 -> LW @0x20 = 0x1122AA44.
  - Then SH 0xBEEF @0x22 -> LW = 0xBEEFAA44.
- Extension: with word 0x80FF7F01 @0x40:
  - LB @0x42 = 0xFFFFFFFF; LBU @0x43 = 0x00000080;
  - LH @0x42 = 0xFFFF80FF; LHU @0x40 = 0x00007F01.
- Faults:
  - LW @0x22 -> `rsp_fault=1`, `rdata=0`;
  - SH @0x41 -> fault, and word @0x40 is unchanged;
  - LW @0x100 (ADDR_WIDTH=6) -> fault;
  - load funct3 011 -> fault.
- Back-to-back: SW 0x5 @0x0, LW @0x0, LW @0x4 on consecutive cycles -> `rsp_valid` high for 3 consecutive cycles; load data 0x5, then the contents of 0x4.
- Parameter sweep: ADDR_WIDTH=10, SW/LW at top word 0xFFC round-trips; 0x1000 faults.
